// File: rtl/smac_accumulator.sv
// Result-accumulation stage behind the sub-word MAC chain: sums a programmed number of
// packed product beats per lane with signed saturation and hands the result off via valid/ready.
module smac_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [3:0]       cfg_precision,
    input  logic             cfg_chain,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [3:0]       out_sat,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_next;
    logic [LEN_W-1:0] len, count;
    logic [3:0]       precision;
    logic             chain;
    logic [63:0]      acc, acc_sum;
    logic [3:0]       sat, sat_sum;
    logic             beat, last_beat;

    logic [8:0]  s0, s1;
    logic [16:0] s2;
    logic [32:0] s3;
    logic [64:0] sc;
    logic        ovf0, ovf1, ovf2, ovf3, ovfc;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beat      = in_valid && in_ready;
    // count holds beats already accepted, so it never exceeds len-1 and cannot wrap
    assign last_beat = beat && (count == len - LEN_W'(1));

    // One sign-extended adder per lane; the extra MSB disagreeing with the lane MSB flags overflow
    always_comb begin
        acc_sum = '0;
        sat_sum = '0;
        s0   = {acc[7], acc[7:0]}     + {in_data[7], in_data[7:0]};
        s1   = {acc[15], acc[15:8]}   + {in_data[15], in_data[15:8]};
        s2   = {acc[31], acc[31:16]}  + {in_data[31], in_data[31:16]};
        s3   = {acc[63], acc[63:32]}  + {in_data[63], in_data[63:32]};
        sc   = {acc[63], acc}         + {in_data[63], in_data};
        ovf0 = s0[8] ^ s0[7];
        ovf1 = s1[8] ^ s1[7];
        ovf2 = s2[16] ^ s2[15];
        ovf3 = s3[32] ^ s3[31];
        ovfc = sc[64] ^ sc[63];
        if (chain) begin
            acc_sum    = ovfc ? {sc[64], {63{~sc[64]}}} : sc[63:0];
            sat_sum[3] = sat[3] | ovfc;
        end else begin
            if (precision[0]) begin
                acc_sum[7:0] = ovf0 ? {s0[8], {7{~s0[8]}}} : s0[7:0];
                sat_sum[0]   = sat[0] | ovf0;
            end
            if (precision[1]) begin
                acc_sum[15:8] = ovf1 ? {s1[8], {7{~s1[8]}}} : s1[7:0];
                sat_sum[1]    = sat[1] | ovf1;
            end
            if (precision[2]) begin
                acc_sum[31:16] = ovf2 ? {s2[16], {15{~s2[16]}}} : s2[15:0];
                sat_sum[2]     = sat[2] | ovf2;
            end
            if (precision[3]) begin
                acc_sum[63:32] = ovf3 ? {s3[32], {31{~s3[32]}}} : s3[31:0];
                sat_sum[3]     = sat[3] | ovf3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            len       <= '0;
            count     <= '0;
            precision <= '0;
            chain     <= 1'b0;
            acc       <= '0;
            sat       <= '0;
            out_data  <= '0;
            out_sat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        len       <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                        precision <= cfg_precision;
                        chain     <= cfg_chain;
                        count     <= '0;
                        acc       <= '0;
                        sat       <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= acc_sum;
                        sat   <= sat_sum;
                        count <= count + LEN_W'(1);
                    end
                    if (last_beat) begin
                        out_data <= acc_sum;
                        out_sat  <= sat_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
